// File: rtl/disp_pkg.sv
// Shared constants and types for the 4-digit seven-segment display mux (driver and demux).
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned AN_W       = NUM_DIGITS;
    localparam int unsigned SSEG_W     = 8;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [AN_W-1:0] AN_BLANK = {AN_W{1'b1}};

    typedef struct packed {
        logic [AN_W-1:0]   an;
        logic [SSEG_W-1:0] sseg;
    } disp_bus_t;

    localparam int unsigned BUS_W   = $bits(disp_bus_t);
    localparam disp_bus_t   BUS_RST = '{an: AN_BLANK, sseg: '0};

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } onecold_t;

    // Exactly one low bit selects a digit; anything else is not a digit select.
    function automatic onecold_t onecold_idx(input logic [AN_W-1:0] an);
        onecold_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (an == ~(AN_W'(1) << k)) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_demux_if.sv
// Display pin bus seen by the demux plus the rebuilt per-digit results.
interface disp_demux_if;
    import disp_pkg::*;

    logic [AN_W-1:0]   an_in;
    logic [SSEG_W-1:0] sseg_in;
    logic [SSEG_W-1:0] out0;
    logic [SSEG_W-1:0] out1;
    logic [SSEG_W-1:0] out2;
    logic [SSEG_W-1:0] out3;
    logic [AN_W-1:0]   digit_vld;
    logic              frame_stb;
    logic              err;
    logic              stale;

    modport master (
        output an_in, sseg_in,
        input  out0, out1, out2, out3, digit_vld, frame_stb, err, stale
    );

    modport slave (
        input  an_in, sseg_in,
        output out0, out1, out2, out3, digit_vld, frame_stb, err, stale
    );

endinterface

// File: rtl/in_stabilizer.sv
// Two-flop synchronizer followed by a saturating stability counter; emits one
// sample pulse per window in which the synchronized data has held still.
module in_stabilizer #(
    parameter int unsigned         WIDTH      = 12,
    parameter int unsigned         STABLE_CYC = 4,
    parameter logic [WIDTH-1:0]    RST_VAL    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             sample_c
);

    localparam int unsigned CNT_W = 4;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q,  prev_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             same_c;

    assign same_c   = (sync2_q == prev_q);
    assign sample_c = same_c && (cnt_q == CNT_W'(STABLE_CYC - 1));
    assign dout     = sync2_q;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cnt_d   = cnt_q;
        if (!same_c) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_CYC)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            prev_q  <= RST_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_demux.sv
// Rebuilds the four digit bytes of a multiplexed seven-segment bus, flags
// completed refresh frames, illegal digit selects and a stalled display.
module disp_demux
    import disp_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned TIMEOUT_W  = 20
) (
    input  logic          clk,
    input  logic          reset,
    disp_demux_if.slave   bus
);

    logic [BUS_W-1:0] stab_data;
    disp_bus_t        bus_in;
    disp_bus_t        bus_stab;
    logic             sample_c;
    onecold_t         dec;
    logic             capture_c;
    logic             illegal_c;

    logic [NUM_DIGITS-1:0][SSEG_W-1:0] out_q, out_d;
    logic [NUM_DIGITS-1:0]             seen_q, seen_d, seen_nx;
    logic                              frame_stb_q, frame_stb_d;
    logic                              err_q, err_d;
    logic [TIMEOUT_W-1:0]              stale_cnt_q, stale_cnt_d;
    logic                              stale_q, stale_d;

    assign bus_in = '{an: bus.an_in, sseg: bus.sseg_in};

    in_stabilizer #(
        .WIDTH      (BUS_W),
        .STABLE_CYC (STABLE_CYC),
        .RST_VAL    (BUS_RST)
    ) u_in_stabilizer (
        .clk      (clk),
        .reset    (reset),
        .din      (bus_in),
        .dout     (stab_data),
        .sample_c (sample_c)
    );

    assign bus_stab  = disp_bus_t'(stab_data);
    assign dec       = onecold_idx(bus_stab.an);
    assign capture_c = sample_c && dec.valid;
    // Blank is a legal idle pattern: neither a capture nor an error.
    assign illegal_c = sample_c && !dec.valid && (bus_stab.an != AN_BLANK);

    always_comb begin
        out_d       = out_q;
        seen_d      = seen_q;
        seen_nx     = seen_q;
        frame_stb_d = 1'b0;
        err_d       = illegal_c;
        stale_cnt_d = stale_cnt_q;

        if (capture_c) begin
            out_d[dec.idx] = bus_stab.sseg;
            seen_nx        = seen_q | (NUM_DIGITS'(1) << dec.idx);
            if (&seen_nx) begin
                frame_stb_d = 1'b1;
                seen_d      = '0;
            end else begin
                seen_d = seen_nx;
            end
        end

        // A capture on the threshold cycle wins over the timeout.
        if (capture_c) begin
            stale_cnt_d = '0;
        end else if (!(&stale_cnt_q)) begin
            stale_cnt_d = stale_cnt_q + TIMEOUT_W'(1);
        end
        stale_d = &stale_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q       <= '0;
            seen_q      <= '0;
            frame_stb_q <= 1'b0;
            err_q       <= 1'b0;
            stale_cnt_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            out_q       <= out_d;
            seen_q      <= seen_d;
            frame_stb_q <= frame_stb_d;
            err_q       <= err_d;
            stale_cnt_q <= stale_cnt_d;
            stale_q     <= stale_d;
        end
    end

    assign bus.out0      = out_q[0];
    assign bus.out1      = out_q[1];
    assign bus.out2      = out_q[2];
    assign bus.out3      = out_q[3];
    assign bus.digit_vld = seen_q;
    assign bus.frame_stb = frame_stb_q;
    assign bus.err       = err_q;
    assign bus.stale     = stale_q;

endmodule

// File: tb/tb_disp_demux.sv
// Bench for disp_demux: directed test-plan steps then random pin traffic,
// every cycle compared against a pin-history reference model.
module tb_disp_demux;
    import disp_pkg::*;

    localparam int unsigned STABLE_CYC = 4;
    localparam int unsigned TIMEOUT_W  = 4;
    localparam int unsigned STALE_AT   = (1 << TIMEOUT_W) - 1;
    localparam int unsigned HMAX       = 8192;
    localparam logic [12:0] H_SENT     = 13'h1000;
    localparam logic [12:0] H_RST      = {1'b0, 4'hF, 8'h00};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    disp_demux_if bus ();

    disp_demux #(
        .STABLE_CYC (STABLE_CYC),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: hist[i] is the pin value present before edge i (bit 12 marks "no value").
    logic [12:0]  hist [HMAX];
    int unsigned  n;
    logic [7:0]   m_out [4];
    logic [3:0]   m_seen;
    logic         m_frame;
    logic         m_err;
    int unsigned  m_since;

    int vectors;
    int miscompares;
    int frame_cnt;
    int err_cnt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (model edge %0d)", tag, obs, exp, n);
        end
    endtask

    // A capture happens when the value two edges back has been present for
    // exactly STABLE_CYC+1 consecutive edges.
    task automatic model_edge(input logic rst, input logic [11:0] pin);
        logic [12:0] v;
        int unsigned run;
        int          idx;
        n++;
        m_frame = 1'b0;
        m_err   = 1'b0;
        if (!rst) begin
            hist[n]   = H_RST;
            hist[n-1] = H_RST;
            hist[n-2] = H_RST;
            hist[n-3] = H_SENT;
            for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
            m_seen  = 4'b0000;
            m_since = 0;
        end else begin
            hist[n] = {1'b0, pin};
            m_since++;
            v   = hist[n-2];
            run = 0;
            while (run <= STABLE_CYC + 1 && hist[n-2-run] == v) run++;
            if (run == STABLE_CYC + 1) begin
                if (v[11:8] == 4'hF) begin
                    // blank
                end else if ($countones(~v[11:8]) == 1) begin
                    idx = 0;
                    for (int k = 0; k < 4; k++) if (v[8+k] == 1'b0) idx = k;
                    m_out[idx] = v[7:0];
                    m_since    = 0;
                    m_seen[idx] = 1'b1;
                    if (m_seen == 4'hF) begin
                        m_frame = 1'b1;
                        m_seen  = 4'b0000;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("out0",      bus.out0, m_out[0]);
        chk("out1",      bus.out1, m_out[1]);
        chk("out2",      bus.out2, m_out[2]);
        chk("out3",      bus.out3, m_out[3]);
        chk("digit_vld", {4'b0, bus.digit_vld}, {4'b0, m_seen});
        chk("frame_stb", {7'b0, bus.frame_stb}, {7'b0, m_frame});
        chk("err",       {7'b0, bus.err},       {7'b0, m_err});
        chk("stale",     {7'b0, bus.stale},     {7'b0, (m_since >= STALE_AT)});
    endtask

    task automatic step(input logic [3:0] an, input logic [7:0] sseg, input logic rst);
        bus.an_in   = an;
        bus.sseg_in = sseg;
        reset       = rst;
        @(posedge clk);
        model_edge(rst, {an, sseg});
        @(negedge clk);
        check_all();
        if (bus.frame_stb === 1'b1) frame_cnt++;
        if (bus.err === 1'b1) err_cnt++;
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] sseg, input int cycles);
        for (int i = 0; i < cycles; i++) step(an, sseg, 1'b1);
    endtask

    initial begin
        logic [3:0] a;
        logic [7:0] s;
        int         kind;
        int         len;

        for (int i = 0; i < HMAX; i++) hist[i] = H_SENT;
        n           = 16;
        vectors     = 0;
        miscompares = 0;
        frame_cnt   = 0;
        err_cnt     = 0;
        m_seen      = 4'b0000;
        m_since     = 0;
        m_frame     = 1'b0;
        m_err       = 1'b0;
        for (int k = 0; k < 4; k++) m_out[k] = 8'h00;

        repeat (3) step(4'hF, 8'h00, 1'b0);
        chk("rst_out0", bus.out0, 8'h00);

        // First capture: pins from edge 0, out0 updates at edge 6.
        hold(4'hE, 8'hC0, 6);
        chk("t1_out0_early", bus.out0, 8'h00);
        step(4'hE, 8'hC0, 1'b1);
        chk("t1_out0", bus.out0, 8'hC0);
        chk("t1_vld", {4'b0, bus.digit_vld}, 8'h01);
        chk("t1_frame", {7'b0, bus.frame_stb}, 8'h00);

        // Full refresh cycle.
        frame_cnt = 0;
        hold(4'hE, 8'h11, 10);
        hold(4'hD, 8'h22, 10);
        hold(4'hB, 8'h33, 10);
        hold(4'h7, 8'h44, 10);
        chk("t2_frames", 8'(frame_cnt), 8'd1);
        chk("t2_out0", bus.out0, 8'h11);
        chk("t2_out1", bus.out1, 8'h22);
        chk("t2_out2", bus.out2, 8'h33);
        chk("t2_out3", bus.out3, 8'h44);
        chk("t2_vld", {4'b0, bus.digit_vld}, 8'h00);

        // Short glitch on digit 1 is ignored.
        err_cnt = 0;
        hold(4'hD, 8'h55, 3);
        hold(4'hF, 8'h00, 10);
        chk("t3_out1", bus.out1, 8'h22);
        chk("t3_err", 8'(err_cnt), 8'd0);

        // Illegal pattern held: exactly one err pulse.
        hold(4'hC, 8'h99, 10);
        hold(4'hF, 8'h00, 10);
        chk("t4_err", 8'(err_cnt), 8'd1);
        chk("t4_out0", bus.out0, 8'h11);
        chk("t4_vld", {4'b0, bus.digit_vld}, 8'h00);

        // Stale timeout then recovery on a capture.
        hold(4'hF, 8'h00, 20);
        chk("t5_stale", {7'b0, bus.stale}, 8'h01);
        chk("t5_out3", bus.out3, 8'h44);
        hold(4'hE, 8'h5A, 7);
        chk("t5_stale_clr", {7'b0, bus.stale}, 8'h00);
        chk("t5_out0", bus.out0, 8'h5A);

        // Mid-frame reset discards partial progress.
        hold(4'hE, 8'h01, 8);
        hold(4'hD, 8'h02, 8);
        step(4'hD, 8'h02, 1'b0);
        chk("t6_out1_rst", bus.out1, 8'h00);
        chk("t6_vld_rst", {4'b0, bus.digit_vld}, 8'h00);
        frame_cnt = 0;
        hold(4'hB, 8'h03, 8);
        hold(4'h7, 8'h04, 8);
        hold(4'hE, 8'h05, 8);
        chk("t6_no_frame", 8'(frame_cnt), 8'd0);
        hold(4'hD, 8'h06, 8);
        chk("t6_frame", 8'(frame_cnt), 8'd1);

        // Random traffic.
        for (int seg = 0; seg < 220; seg++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 12));
            s    = 8'($urandom);
            if (kind <= 5) begin
                a = ~(4'b0001 << $urandom_range(0, 3));
                hold(a, s, len);
            end else if (kind <= 7) begin
                hold(4'hF, s, len);
            end else if (kind == 8) begin
                do a = 4'($urandom); while ($countones(~a) < 2);
                hold(a, s, len);
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 2)); i++) step(4'hF, s, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/disp_demux.md
# disp_demux

Receive-side counterpart of the 4-digit multiplexed seven-segment display driver. It watches a time-multiplexed, active-low digit-enable bus and an 8-bit segment bus, rebuilds the four per-digit segment bytes into registers, and flags each completed refresh frame. It sits behind the display pins, for board-level loopback and self-test. It also serves as the input stage when a block downstream must read back what a display mux is showing.

## Interface
- STABLE_CYC, 4: consecutive cycles the synchronized {an_in, sseg_in} must hold before a sample is taken; legal 2..15.
- TIMEOUT_W, 20: stale-counter width; stale asserts after 2^TIMEOUT_W−1 cycles with no valid capture.
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-low reset.
- an_in  in  4  digit enables, active-low; one-cold = digit select, 4'b1111 = blank.
- sseg_in  in  8  segment byte for the currently enabled digit.
- out0, out1, out2, out3  out  8 each  last captured segment byte for digit 0..3 (an bit 0..3 low).
- digit_vld  out  4  bit k set once digit k has been captured in the current frame.
- frame_stb  out  1  one-cycle pulse when all four digits have been captured since the last pulse.
- err  out  1  one-cycle pulse on a stable, illegal an pattern (two or more bits low).
- stale  out  1  level; no valid capture for the timeout period.

## Operation
- Both input buses pass through a 2-flop synchronizer. Sync flops reset to an=4'b1111 and sseg=8'h00.
- Stability counter (4-bit, saturating at STABLE_CYC):
  - Clears whenever the synchronized {an,sseg} differs from its value on the previous cycle.
  - Otherwise increments.
- A sample event fires exactly once per stable window, on the cycle the counter goes from STABLE_CYC−1 to STABLE_CYC. Nothing fires while the counter stays saturated.
- On a sample event, decode an:
  - One-cold, digit k: out_k ← sseg, and digit k is marked seen. Recapturing the same digit overwrites out_k; seen is unchanged.
  - 4'b1111: blank. No capture, no error, stale counter not cleared.
  - Any other pattern: err pulses. No capture; outputs unchanged.
- Frame completion: if seen | newbit == 4'b1111, frame_stb pulses in that cycle and seen clears to 0 in the same cycle. digit_vld reflects the registered seen.
- Stale counter:
  - Increments every cycle and saturates at all-ones.
  - Clears on every valid digit capture.
  - stale = (counter == all-ones).
  - out0..out3 hold their values while stale.
- Reset (reset low at an edge): out0..3=8'h00, digit_vld=0, frame_stb=0, err=0, stale=0, and all counters and sync flops return to their reset values. A mid-frame reset discards partial seen state; the next frame must capture all four digits.

## Timing
- Pin pattern changed before edge t and held: the synchronized value appears at edge t+2, and out_k updates at edge t+2+STABLE_CYC.
- frame_stb and err are asserted for exactly one cycle, in the same cycle that out_k updates.
- A pattern held for fewer than STABLE_CYC synchronized cycles (glitch or ghosting) produces no capture and no err.
- A stale-threshold crossing and a capture in the same cycle: the capture wins, the counter clears, and stale stays 0.
- Throughput: at most one capture per STABLE_CYC+1 cycles.

## Structure
- Shared package disp_pkg holds:
  - NUM_DIGITS=4
  - AN_BLANK=4'b1111
  - function onecold_idx(an) returning a valid flag and a 2-bit index.
  - The transmit driver reuses the same constants.
- Sub-module in_stabilizer: 2-flop sync plus stability counter, parameterized on data width (12) and STABLE_CYC. Outputs are the stable data and a sample pulse.
- The top level holds decode, output registers, seen/frame logic and the stale counter.

## Test plan
- STABLE_CYC=4. Drive an=1110, sseg=8'hC0 from edge 0 → out0=8'hC0 at edge 6; digit_vld=0001; no frame_stb.
- Cycle an through 1110/1101/1011/0111 with sseg 8'h11/22/33/44, each held 10 cycles:
  - → out0..3 = 11/22/33/44.
  - → frame_stb pulses once, in the cycle of the digit-3 capture.
  - → digit_vld returns to 0000 on the following cycle.
- Hold an=1101 for 3 synchronized cycles, then switch to 1111 → out1 unchanged, no err.
- Hold an=1100 for 10 cycles → exactly one err pulse; out0..3 and digit_vld unchanged.
- TIMEOUT_W=4, an held at 1111 → stale=1 at cycle 15 after the last capture. A subsequent an=1110 capture → stale=0 in the capture cycle, with outputs retained throughout.
- Capture digits 0 and 1, pulse reset low for one edge → all outputs 0. Then three more digits captured (2, 3, 0) → no frame_stb until digit 1 is also captured.
